// File: rtl/sa_deskew.sv
// Systolic-array output deskew: per-lane delay lines realign the diagonal wavefront into whole
// row words, buffered in a FIFO and presented as an AXI-Stream master. Option: SA_DESKEW_CHECK_EN.
module sa_deskew #(
  parameter int unsigned R     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       c,
  input  logic                       r,
  input  logic [R*W-1:0]             s_data,
  input  logic [R-1:0]               s_valid,
  input  logic                       s_last,
  output logic [R*W-1:0]             m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic [$clog2(DEPTH):0]     count,
`ifdef SA_DESKEW_CHECK_EN
  output logic                       algn_err,
`endif
  output logic                       ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [R*W-1:0] w_data;
  logic [R-1:0]   w_vld;

  // Lane k sits R-1-k registers deep so every lane reaches the alignment point together.
  for (genvar k = 0; k < int'(R); k++) begin : g_lane
    localparam int D = int'(R) - 1 - k;
`ifdef SA_DESKEW_CHECK_EN
    localparam bit TrackV = 1'b1;
`else
    localparam bit TrackV = (k == 0);
`endif
    if (D == 0) begin : g_tap
      assign w_data[k*W +: W] = s_data[k*W +: W];
      if (TrackV) begin : g_v
        assign w_vld[k] = s_valid[k];
      end else begin : g_nv
        assign w_vld[k] = 1'b0;
      end
    end else begin : g_dly
      logic [W-1:0] r_dat [D];
      always_ff @(posedge c) begin
        if (r) begin
          for (int i = 0; i < D; i++) r_dat[i] <= '0;
        end else begin
          r_dat[0] <= s_data[k*W +: W];
          for (int i = 1; i < D; i++) r_dat[i] <= r_dat[i-1];
        end
      end
      assign w_data[k*W +: W] = r_dat[D-1];

      if (TrackV) begin : g_v
        logic [D-1:0] r_vld;
        always_ff @(posedge c) begin
          if (r) begin
            r_vld <= '0;
          end else begin
            r_vld[0] <= s_valid[k];
            for (int i = 1; i < D; i++) r_vld[i] <= r_vld[i-1];
          end
        end
        assign w_vld[k] = r_vld[D-1];
      end else begin : g_nv
        assign w_vld[k] = 1'b0;
      end
    end
  end

  logic [R*W:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          w_wr, w_pop, w_full, w_push;
  logic [R*W:0]  w_head;

  assign w_wr   = w_vld[0];
  assign w_pop  = m_valid & m_ready;
  assign w_full = (r_cnt == CW'(DEPTH));
  // When full, a same-cycle pop frees the slot the push lands in.
  assign w_push = w_wr & (~w_full | w_pop);

  always_ff @(posedge c) begin
    if (w_push) r_mem[r_wptr] <= {s_last, w_data};
  end

  always_ff @(posedge c) begin
    if (r) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
      if (w_wr && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign w_head  = r_mem[r_rptr];
  assign m_valid = (r_cnt != '0);
  assign m_data  = w_head[R*W-1:0];
  assign m_last  = m_valid & w_head[R*W];
  assign count   = r_cnt;
  assign ovf     = r_ovf;

`ifdef SA_DESKEW_CHECK_EN
  always_ff @(posedge c) begin
    if (r) begin
      algn_err <= 1'b0;
    end else if ((|w_vld) && !(&w_vld)) begin
      algn_err <= 1'b1;
    end
  end
`else
  logic w_unused_vld;
  assign w_unused_vld = ^{s_valid, w_vld};
`endif

endmodule
